terminal_writer: RTL and testbench

Parametrised successor to the fixed-size character-to-VRAM writer. It accepts character bytes over a ready/valid stream, such as decoded PS/2 characters. Printable bytes are written into VRAM at a tracked cursor, and CR, LF, BS, TAB and FF are interpreted as terminal controls. The block owns hardware scrolling: it drives `top_row` to the HDMI block in place of a constant 0, and it clears the row that is about to scroll into view.

---
 rtl/terminal_writer.sv | 239 +++++++++++++++++++++++
 tb/tb_terminal_writer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/terminal_writer.sv
// terminal_writer: turns a stream of character bytes into VRAM writes with a
// tracked cursor and hardware scrolling.
//
// Printable bytes (0x20..0x7E) are written at the cursor. CR, LF, BS, TAB and
// FF act as terminal controls. All other bytes are dropped. VRAM holds
// 2**ROW_BITS physical rows that are used as a ring. top_row selects the
// physical row that is shown as screen line 0. When the cursor would move
// below the last visible row, the row just past the visible window is blanked
// first. top_row then advances, so a stale line never becomes visible.
//
// Ports
//   clk, reset_low        clock, asynchronous active-low reset
//   character_*           ready/valid byte input
//   write_*               ready/valid VRAM write port (physical row, column, byte)
//   top_row               physical row shown as screen line 0
//   cursor_row/col        logical cursor position
module terminal_writer #(
  parameter int          ROWS      = 24,
  parameter int          COLS      = 80,
  parameter int          ROW_BITS  = 5,
  parameter int          COL_BITS  = 7,
  parameter int          TAB_WIDTH = 8,
  parameter logic [7:0]  BLANK     = 8'h20
) (
  input  logic                clk,
  input  logic                reset_low,
  output logic                character_ready,
  input  logic                character_valid,
  input  logic [7:0]          character_byte,
  input  logic                write_ready,
  output logic                write_valid,
  output logic [ROW_BITS-1:0] write_row,
  output logic [COL_BITS-1:0] write_col,
  output logic [7:0]          write_byte,
  output logic [ROW_BITS-1:0] top_row,
  output logic [ROW_BITS-1:0] cursor_row,
  output logic [COL_BITS-1:0] cursor_col
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PUT,
    S_CLEAR_LINE,
    S_CLEAR_SCREEN
  } state_t;

  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(ROWS - 1);
  localparam logic [ROW_BITS-1:0] ROWS_R   = ROW_BITS'(ROWS);
  localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(COLS - 1);
  localparam logic [COL_BITS-1:0] TAB_MASK = COL_BITS'(TAB_WIDTH - 1);

  state_t              state_q, state_d;
  logic                ready_q, ready_d;
  logic                wvalid_q, wvalid_d;
  logic [ROW_BITS-1:0] wrow_q, wrow_d;
  logic [COL_BITS-1:0] wcol_q, wcol_d;
  logic [7:0]          wbyte_q, wbyte_d;
  logic [ROW_BITS-1:0] top_q, top_d;
  logic [ROW_BITS-1:0] crow_q, crow_d;
  logic [COL_BITS-1:0] ccol_q, ccol_d;
  // Clear counters: logical row / column of the clear write currently offered.
  logic [ROW_BITS-1:0] clr_row_q, clr_row_d;
  logic [COL_BITS-1:0] clr_col_q, clr_col_d;

  logic                do_newline;
  logic                accept;
  logic                wr_done;
  logic [COL_BITS:0]   tab_sum;
  logic [COL_BITS-1:0] tab_col;

  assign accept  = ready_q & character_valid;
  assign wr_done = wvalid_q & write_ready;

  // The next tab stop is computed one bit wider so that a stop at or past COLS
  // clamps to the last column instead of wrapping.
  assign tab_sum = {1'b0, ccol_q | TAB_MASK} + (COL_BITS + 1)'(1);
  assign tab_col = (tab_sum > {1'b0, LAST_COL}) ? LAST_COL : tab_sum[COL_BITS-1:0];

  always_comb begin
    state_d    = state_q;
    ready_d    = ready_q;
    wvalid_d   = wvalid_q;
    wrow_d     = wrow_q;
    wcol_d     = wcol_q;
    wbyte_d    = wbyte_q;
    top_d      = top_q;
    crow_d     = crow_q;
    ccol_d     = ccol_q;
    clr_row_d  = clr_row_q;
    clr_col_d  = clr_col_q;
    do_newline = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!ready_q) begin
          // One idle bubble after a control byte so ready stays low for a cycle.
          ready_d = 1'b1;
        end else if (accept) begin
          ready_d = 1'b0;
          if (character_byte >= 8'h20 && character_byte <= 8'h7E) begin
            state_d  = S_PUT;
            wvalid_d = 1'b1;
            wrow_d   = top_q + crow_q;
            wcol_d   = ccol_q;
            wbyte_d  = character_byte;
          end else begin
            unique case (character_byte)
              8'h0D: ccol_d = '0;
              8'h0A: do_newline = 1'b1;
              8'h08: if (ccol_q != '0) ccol_d = ccol_q - COL_BITS'(1);
              8'h09: ccol_d = tab_col;
              8'h0C: begin
                state_d   = S_CLEAR_SCREEN;
                clr_row_d = '0;
                clr_col_d = '0;
              end
              default: ;
            endcase
          end
        end
      end

      S_PUT: begin
        if (wr_done) begin
          wvalid_d = 1'b0;
          if (ccol_q < LAST_COL) begin
            ccol_d  = ccol_q + COL_BITS'(1);
            state_d = S_IDLE;
            ready_d = 1'b1;
          end else begin
            ccol_d     = '0;
            do_newline = 1'b1;
          end
        end
      end

      S_CLEAR_LINE: begin
        if (!wvalid_q) begin
          wvalid_d = 1'b1;
          wrow_d   = top_q + ROWS_R;
          wcol_d   = clr_col_q;
          wbyte_d  = BLANK;
        end else if (write_ready) begin
          if (clr_col_q == LAST_COL) begin
            wvalid_d = 1'b0;
            top_d    = top_q + ROW_BITS'(1);
            state_d  = S_IDLE;
            ready_d  = 1'b1;
          end else begin
            clr_col_d = clr_col_q + COL_BITS'(1);
            wcol_d    = clr_col_q + COL_BITS'(1);
          end
        end
      end

      S_CLEAR_SCREEN: begin
        if (!wvalid_q) begin
          wvalid_d = 1'b1;
          wrow_d   = top_q + clr_row_q;
          wcol_d   = clr_col_q;
          wbyte_d  = BLANK;
        end else if (write_ready) begin
          if (clr_col_q == LAST_COL) begin
            if (clr_row_q == LAST_ROW) begin
              wvalid_d  = 1'b0;
              clr_row_d = '0;
              clr_col_d = '0;
              crow_d    = '0;
              ccol_d    = '0;
              state_d   = S_IDLE;
              ready_d   = 1'b1;
            end else begin
              clr_row_d = clr_row_q + ROW_BITS'(1);
              clr_col_d = '0;
              wrow_d    = top_q + clr_row_q + ROW_BITS'(1);
              wcol_d    = '0;
            end
          end else begin
            clr_col_d = clr_col_q + COL_BITS'(1);
            wcol_d    = clr_col_q + COL_BITS'(1);
          end
        end
      end

      default: state_d = S_CLEAR_SCREEN;
    endcase

    // Shared by LF and by the wrap after a write to the last column.
    if (do_newline) begin
      if (crow_q < LAST_ROW) begin
        crow_d  = crow_q + ROW_BITS'(1);
        state_d = S_IDLE;
        // After a wrapped PUT, ready returns at once. After LF, the idle bubble applies.
        ready_d = (state_q == S_PUT);
      end else begin
        state_d   = S_CLEAR_LINE;
        clr_col_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      state_q   <= S_CLEAR_SCREEN;
      ready_q   <= 1'b0;
      wvalid_q  <= 1'b0;
      wrow_q    <= '0;
      wcol_q    <= '0;
      wbyte_q   <= BLANK;
      top_q     <= '0;
      crow_q    <= '0;
      ccol_q    <= '0;
      clr_row_q <= '0;
      clr_col_q <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      wvalid_q  <= wvalid_d;
      wrow_q    <= wrow_d;
      wcol_q    <= wcol_d;
      wbyte_q   <= wbyte_d;
      top_q     <= top_d;
      crow_q    <= crow_d;
      ccol_q    <= ccol_d;
      clr_row_q <= clr_row_d;
      clr_col_q <= clr_col_d;
    end
  end

  assign character_ready = ready_q;
  assign write_valid     = wvalid_q;
  assign write_row       = wrow_q;
  assign write_col       = wcol_q;
  assign write_byte      = wbyte_q;
  assign top_row         = top_q;
  assign cursor_row      = crow_q;
  assign cursor_col      = ccol_q;

endmodule

// File: tb/tb_terminal_writer.sv
// Bench for terminal_writer (default parameters). A behavioural terminal model
// predicts the ordered list of VRAM writes and the resulting cursor and top row.
// It is compared against writes collected from the DUT port.
module tb_terminal_writer;
  localparam int ROWS = 24;
  localparam int COLS = 80;
  localparam int NPHYS = 32;

  logic       clk = 1'b0;
  logic       reset_low = 1'b0;
  logic       character_ready;
  logic       character_valid = 1'b0;
  logic [7:0] character_byte = 8'h00;
  logic       write_ready = 1'b0;
  logic       write_valid;
  logic [4:0] write_row;
  logic [6:0] write_col;
  logic [7:0] write_byte;
  logic [4:0] top_row;
  logic [4:0] cursor_row;
  logic [6:0] cursor_col;

  terminal_writer dut (
    .clk             (clk),
    .reset_low       (reset_low),
    .character_ready (character_ready),
    .character_valid (character_valid),
    .character_byte  (character_byte),
    .write_ready     (write_ready),
    .write_valid     (write_valid),
    .write_row       (write_row),
    .write_col       (write_col),
    .write_byte      (write_byte),
    .top_row         (top_row),
    .cursor_row      (cursor_row),
    .cursor_col      (cursor_col)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: held low
  int stall_err = 0;
  logic [19:0] act_q[$];
  logic [19:0] exp_q[$];
  int m_row, m_col, m_top;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // VRAM-side ready generator.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       write_ready = 1'b1;
        1:       write_ready = ($urandom % 4) != 0;
        default: write_ready = 1'b0;
      endcase
    end
  end

  // Write monitor: record completed writes, flag unstable stalled requests.
  logic        prev_stall = 1'b0;
  logic [19:0] prev_w = '0;
  always @(negedge clk) begin
    if (!reset_low) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && !(write_valid && {write_row, write_col, write_byte} == prev_w))
        stall_err <= stall_err + 1;
      if (write_valid && write_ready)
        act_q.push_back({write_row, write_col, write_byte});
      prev_stall <= write_valid && !write_ready;
      prev_w     <= {write_row, write_col, write_byte};
    end
  end

  // ---------------- reference model ----------------
  task automatic push_w(input int row, input int col, input logic [7:0] b);
    logic [4:0] r;
    logic [6:0] c;
    r = 5'(row % NPHYS);
    c = 7'(col);
    exp_q.push_back({r, c, b});
  endtask

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        push_w(m_top + r, c, 8'h20);
    m_row = 0;
    m_col = 0;
  endtask

  task automatic model_nl();
    if (m_row < ROWS - 1) m_row++;
    else begin
      for (int c = 0; c < COLS; c++) push_w(m_top + ROWS, c, 8'h20);
      m_top = (m_top + 1) % NPHYS;
    end
  endtask

  task automatic model_char(input logic [7:0] b);
    int t;
    if (b >= 8'h20 && b <= 8'h7E) begin
      push_w(m_top + m_row, m_col, b);
      if (m_col < COLS - 1) m_col++;
      else begin
        m_col = 0;
        model_nl();
      end
    end else begin
      case (b)
        8'h0D: m_col = 0;
        8'h0A: model_nl();
        8'h08: if (m_col > 0) m_col--;
        8'h09: begin
          t = (m_col | 7) + 1;
          m_col = (t < COLS - 1) ? t : COLS - 1;
        end
        8'h0C: model_clear();
        default: ;
      endcase
    end
  endtask

  // ---------------- helpers ----------------
  task automatic send_raw(input logic [7:0] b);
    int n;
    @(posedge clk);
    #1;
    character_valid = 1'b1;
    character_byte  = b;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!character_ready && n < 20000);
    if (!character_ready) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    character_valid = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!character_ready && cycles < 20000);
    if (!character_ready) check("idle_timeout", 0, 1);
  endtask

  task automatic compare_writes(input string tag);
    int n;
    int bad;
    check({tag, "_wr_cnt"}, act_q.size(), exp_q.size());
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    bad = -1;
    for (int i = 0; i < n; i++) begin
      if (act_q[i] !== exp_q[i]) begin
        bad = i;
        break;
      end
    end
    if (bad >= 0) check({tag, "_wr_data"}, act_q[bad], exp_q[bad]);
    else if (n > 0) check({tag, "_wr_last"}, act_q[n-1], exp_q[n-1]);
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic check_cursor(input string tag);
    check({tag, "_row"}, cursor_row, m_row);
    check({tag, "_col"}, cursor_col, m_col);
    check({tag, "_top"}, top_row, m_top);
  endtask

  task automatic send_char(input logic [7:0] b, input string tag);
    int cyc;
    model_char(b);
    send_raw(b);
    wait_idle(cyc);
    compare_writes(tag);
    check_cursor(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int n;
    int r;
    logic [7:0] b;

    ready_mode = 0;
    m_row = 0; m_col = 0; m_top = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",  character_ready, 0);
    check("rst_wvalid", write_valid, 0);
    check("rst_addr",   {write_row, write_col}, 0);
    check("rst_byte",   write_byte, 8'h20);
    check("rst_top",    top_row, 0);
    check("rst_cursor", {cursor_row, cursor_col}, 0);

    // Power-up clear of the whole screen.
    model_clear();
    reset_low = 1'b1;
    wait_idle(cyc);
    check("clr_rate", cyc <= 1925, 1);
    compare_writes("pwr_clr");
    check_cursor("pwr_clr");

    // Single character with the VRAM stalled.
    ready_mode = 2;
    @(posedge clk);
    #2;
    model_char(8'h41);
    send_raw(8'h41);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_req", {write_valid, write_row, write_col, write_byte}, {1'b1, 5'd0, 7'd0, 8'h41});
      check("stall_rdy", character_ready, 0);
    end
    ready_mode = 0;
    wait_idle(cyc);
    check("rdy_after_wr", cyc, 2);
    compare_writes("put_a");
    check("put_a_col", cursor_col, 1);

    // Full line of characters wraps to the next row.
    send_char(8'h0D, "cr0");
    for (int i = 0; i < COLS; i++) send_char(8'h78, "line");
    check("wrap_pos", {cursor_row, cursor_col}, {5'd1, 7'd0});
    check("wrap_top", top_row, 0);

    // Control bytes.
    send_char(8'h61, "a"); send_char(8'h62, "b"); send_char(8'h63, "c");
    send_char(8'h09, "tab3");
    check("tab3_col", cursor_col, 8);
    send_char(8'h0D, "cr");
    for (int i = 0; i < 9; i++) send_char(8'h09, "tabs");
    send_char(8'h61, "a"); send_char(8'h62, "b"); send_char(8'h63, "c");
    send_char(8'h09, "tab75");
    check("tab75_col", cursor_col, 79);
    send_char(8'h0D, "cr79");
    send_char(8'h08, "bs0");
    check("bs0_col", cursor_col, 0);
    for (int i = 0; i < 40; i++) send_char(8'h20, "sp");
    send_char(8'h0D, "cr40");
    check("cr40_col", cursor_col, 0);
    send_char(8'h07, "bel");

    // Scroll from the bottom row, then walk top_row all the way round.
    while (m_row < ROWS - 1) send_char(8'h0A, "lf_down");
    for (int i = 0; i < 5; i++) send_char(8'h20, "sp5");
    send_char(8'h0A, "scroll1");
    check("scroll1_pos", {cursor_row, cursor_col}, {5'd23, 7'd5});
    check("scroll1_top", top_row, 1);
    while (m_top != 31) send_char(8'h0A, "scroll_n");
    send_char(8'h0A, "scroll_wrap");
    check("wrap_top0", top_row, 0);

    // Form feed with a non-zero top_row.
    for (int i = 0; i < 5; i++) send_char(8'h0A, "lf5");
    check("ff_top_pre", top_row, 5);
    send_char(8'h0C, "ff");
    check("ff_top_keep", top_row, 5);

    // Reset in the middle of a screen clear.
    send_raw(8'h0C);
    n = 0;
    while (act_q.size() < 100 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("ff_reach100", act_q.size() >= 100, 1);
    #1;
    reset_low = 1'b0;
    #1;
    check("mid_rst_wvalid", write_valid, 0);
    check("mid_rst_top", top_row, 0);
    check("mid_rst_ready", character_ready, 0);
    repeat (2) @(posedge clk);
    act_q.delete();
    exp_q.delete();
    m_top = 0;
    model_clear();
    #1;
    reset_low = 1'b1;
    wait_idle(cyc);
    if (act_q.size() > 0) check("restart_first", act_q[0], {5'd0, 7'd0, 8'h20});
    compare_writes("restart_clr");
    check_cursor("restart_clr");

    // Randomised traffic with a randomly stalling VRAM.
    ready_mode = 1;
    for (int i = 0; i < 300; i++) begin
      r = $urandom % 100;
      if (r < 60)      b = 8'(32 + ($urandom % 95));
      else if (r < 70) b = 8'h0A;
      else if (r < 77) b = 8'h0D;
      else if (r < 84) b = 8'h08;
      else if (r < 92) b = 8'h09;
      else if (r < 99) b = 8'($urandom % 256);
      else             b = 8'h0C;
      send_char(b, "rand");
    end

    check("stall_stable", stall_err, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
